mem_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction fetch path and the data (MEM-stage) path of the pipelined MIPS core.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_arbiter_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: RAM handshake states, data words and the
// memory arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // state | meaning
  // IDLE  | no access outstanding, arbitrating between I and D
  // IACC  | instruction read in flight on the RAM port
  // DACC  | data read or write in flight on the RAM port
  // RESP  | one-cycle completion pulse on the served side's wait
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Per-access watchdog: restarts on every grant, counts while an access is
// outstanding and flags a timeout on the cycle it reaches TIMEOUT-1.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wdog;

  // Cycle counter for the current access; holds at LAST until the next grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog <= '0;
    end else if (clear) begin
      wdog <= '0;
    end else if (count && (wdog != LAST)) begin
      wdog <= wdog + 1'b1;
    end
  end

  assign timeout = count && (wdog == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data wins ties, except after STARVE_MAX consecutive D grants while an
// instruction fetch was waiting, in which case I is forced through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic [1:0]    ramstate,
  output logic          arb_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic          d_req;
  logic          i_forced;
  logic          d_go;
  logic          grant;
  logic          in_access;
  logic          timeout;
  ramstate_t     rs;

  assign rs        = ramstate_t'(ramstate);
  assign d_req     = dREN | dWEN;
  assign i_forced  = iREN && (streak == STREAK_MAX);
  assign d_go      = d_req && !i_forced;
  assign grant     = (state == IDLE) && (d_go || iREN);
  assign in_access = (state == IACC) || (state == DACC);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (grant),
    .count   (in_access),
    .timeout (timeout)
  );

  // Arbitration FSM; the RAM strobes, address and store data double as the
  // latched copy of the granted request so they stay stable for the access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      arb_err  <= 1'b0;
      streak   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_go) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            if (!iREN) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            streak  <= '0;
          end
        end
        IACC, DACC: begin
          if (rs == ACCESS) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= RESP;
            if (state == IACC) begin
              iload <= ramload;
              iwait <= 1'b0;
            end else begin
              if (!ramWEN) dload <= ramload;
              dwait <= 1'b0;
            end
          end else if (rs == ERROR) begin
            // Retry by re-arbitrating; the requester never sees this attempt.
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= IDLE;
          end else if (timeout) begin
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            arb_err <= 1'b1;
            state   <= IDLE;
          end
        end
        RESP: begin
          iwait <= 1'b1;
          dwait <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural RAM responder.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        arb_err;

  // RAM model controls
  int          lat = 0;
  logic        stuck = 1'b0;
  logic        err_once = 1'b0;
  logic [31:0] rd_data = '0;
  int          busy_cnt = 0;

  int n_chk = 0;
  int n_pass = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  assign ramload = rd_data;

  always_comb begin
    ramstate = 2'd0;
    if (ramREN || ramWEN) begin
      if (stuck)               ramstate = 2'd1;
      else if (err_once)       ramstate = 2'd3;
      else if (busy_cnt >= lat) ramstate = 2'd2;
      else                     ramstate = 2'd1;
    end
  end

  always @(posedge CLK) begin
    busy_cnt <= (ramREN || ramWEN) ? busy_cnt + 1 : 0;
    if (ramstate == 2'd3) err_once <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int pulses;
    string seq;
    logic p_str;

    // reset values
    #12;
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_loads", iload | dload | ramstore, 32'd0);
    chk("rst_err", {31'd0, arb_err}, 32'd0);
    @(negedge CLK) RST = 1'b0;
    next_cycle();

    // 1: lone I fetch, 3 BUSY then ACCESS
    lat = 3; rd_data = 32'h8C220004;
    iREN = 1'b1; iaddr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      chk($sformatf("t1_addr_c%0d", c), ramaddr, 32'h40);
      chk($sformatf("t1_ren_iw_c%0d", c), {30'd0, ramREN, iwait}, 32'd3);
    end
    next_cycle();
    chk("t1_iwait_c5", {31'd0, iwait}, 32'd0);
    chk("t1_iload", iload, 32'h8C220004);
    chk("t1_dwait_c5", {31'd0, dwait}, 32'd1);
    iREN = 1'b0;
    next_cycle();
    chk("t1_iwait_c6", {31'd0, iwait}, 32'd1);

    // 2: simultaneous I and D, D first
    lat = 0; rd_data = 32'h12345678;
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    next_cycle();
    chk("t2_c1_daddr", ramaddr, 32'h100);
    chk("t2_c1_ren", {31'd0, ramREN}, 32'd1);
    next_cycle();
    chk("t2_c2_waits", {30'd0, dwait, iwait}, 32'd1);
    chk("t2_dload", dload, 32'h12345678);
    dREN = 1'b0; rd_data = 32'h0BADF00D;
    next_cycle();
    chk("t2_c3_idle", {30'd0, ramREN, dwait}, 32'd1);
    next_cycle();
    chk("t2_c4_iaddr", ramaddr, 32'h80);
    next_cycle();
    chk("t2_c5_waits", {30'd0, dwait, iwait}, 32'd2);
    chk("t2_iload", iload, 32'h0BADF00D);
    iREN = 1'b0;
    next_cycle();

    // 3: starvation limit with D writes held
    rd_data = 32'hCAFEF00D;
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h104; dstore = 32'h1;
    seq = ""; p_str = 1'b0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      if ((ramREN || ramWEN) && !p_str) seq = {seq, ramWEN ? "D" : "I"};
      p_str = ramREN || ramWEN;
    end
    chk("t3_seq_len", (seq.len() >= 9) ? 32'd1 : 32'd0, 32'd1);
    chk("t3_seq_first6", (seq.substr(0, 5) == "DDDDID") ? 32'd1 : 32'd0, 32'd1);
    chk("t3_seq_9", (seq.substr(6, 9) == "DDDI") ? 32'd1 : 32'd0, 32'd1);
    chk("t3_dload_kept", dload, 32'h12345678);
    iREN = 1'b0; dWEN = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();

    // 4: watchdog timeout on a stuck RAM
    stuck = 1'b1; rd_data = 32'hCAFEF00D;
    dREN = 1'b1; daddr = 32'h300;
    hi = 0;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (ramREN) hi++;
      if (c == 16) chk("t4_err_c16", {31'd0, arb_err}, 32'd0);
    end
    chk("t4_hi_cycles", hi, 32'd16);
    next_cycle();
    chk("t4_c17_drop", {30'd0, ramREN, arb_err}, 32'd1);
    chk("t4_c17_dwait", {31'd0, dwait}, 32'd1);
    next_cycle();
    chk("t4_c18_regrant", {30'd0, ramREN, arb_err}, 32'd3);
    stuck = 1'b0;
    next_cycle();
    chk("t4_c19_dwait", {31'd0, dwait}, 32'd0);
    chk("t4_dload", dload, 32'hCAFEF00D);
    dREN = 1'b0;
    next_cycle();
    chk("t4_err_sticky", {31'd0, arb_err}, 32'd1);

    // 5: ERROR then retry on a write
    err_once = 1'b1; rd_data = 32'h55555555;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (!dwait) pulses++;
      if (c == 1 || c == 3) chk($sformatf("t5_store_c%0d", c), ramstore, 32'hDEADBEEF);
      if (c == 1 || c == 3) chk($sformatf("t5_wen_c%0d", c), {30'd0, ramWEN, ramREN}, 32'd2);
      if (c == 2) chk("t5_c2_drop", {30'd0, ramWEN, dwait}, 32'd1);
      if (c == 4) begin
        chk("t5_c4_dwait", {31'd0, dwait}, 32'd0);
        dWEN = 1'b0;
      end
    end
    chk("t5_pulses", pulses, 32'd1);
    chk("t5_dload_kept", dload, 32'hCAFEF00D);

    // 6: reset in the middle of a data access
    stuck = 1'b1;
    dREN = 1'b1; daddr = 32'h400;
    next_cycle();
    chk("t6_c1_ren", {31'd0, ramREN}, 32'd1);
    next_cycle();
    #2 RST = 1'b1;
    #1;
    chk("t6_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("t6_waits", {30'd0, iwait, dwait}, 32'd3);
    chk("t6_regs", iload | dload | ramaddr | ramstore, 32'd0);
    chk("t6_err", {31'd0, arb_err}, 32'd0);
    dREN = 1'b0; stuck = 1'b0;
    @(negedge CLK) RST = 1'b0;
    next_cycle();
    rd_data = 32'h00C0FFEE;
    iREN = 1'b1; iaddr = 32'h44;
    next_cycle();
    chk("t6_post_grant", ramaddr, 32'h44);
    chk("t6_post_ren", {31'd0, ramREN}, 32'd1);
    next_cycle();
    chk("t6_post_iwait", {31'd0, iwait}, 32'd0);
    chk("t6_post_iload", iload, 32'h00C0FFEE);
    iREN = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
